// File: rtl/mssd_frame_tx.sv
// Serial frame transmitter: start bit, 2-bit port, 4-bit length, then payload bytes MSB first
// drawn from an internal byte FIFO. One bit per clock, line idles high.
module mssd_frame_tx #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              Clk,
    input  logic                              reset,
    input  logic                              wrEn,
    input  logic [7:0]                        dataIn,
    input  logic                              start,
    input  logic [1:0]                        portNum,
    input  logic [3:0]                        byteNum,
    output logic                              serOut,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifoCount,
    output logic                              busy,
    output logic                              done,
    output logic                              reject
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STRT = 3'd1,
        S_PORT = 3'd2,
        S_LEN  = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t          r_state_r;
    logic [5:0]      r_hdr_r;
    logic [3:0]      r_len_r;
    logic [1:0]      r_phase_r;
    logic [6:0]      r_bits_r;
    logic [7:0]      r_shift_r;
    logic            r_ser_r;
    logic            r_busy_r;
    logic            r_done_r;
    logic            r_reject_r;

    logic [7:0]      r_mem_r [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr_r;
    logic [PW-1:0]   r_rd_ptr_r;
    logic [CW-1:0]   r_count_r;
    logic            r_full_r;

    logic            w_pop_s;
    logic            w_push_s;
    logic [7:0]      w_rd_data_s;

    assign w_rd_data_s = r_mem_r[r_rd_ptr_r];
    // A full FIFO still takes a byte when the same edge pops one out.
    assign w_push_s    = wrEn & (~r_full_r | w_pop_s);

    // Pop at the end of the header and at every later byte boundary inside the payload.
    always_comb begin
        w_pop_s = 1'b0;
        case (r_state_r)
            S_LEN: begin
                if ((r_phase_r == 2'd3) && (r_len_r != 4'd0)) begin
                    w_pop_s = 1'b1;
                end else begin
                    w_pop_s = 1'b0;
                end
            end
            S_DATA: begin
                if ((r_bits_r != 7'd1) && (r_bits_r[2:0] == 3'b001)) begin
                    w_pop_s = 1'b1;
                end else begin
                    w_pop_s = 1'b0;
                end
            end
            default: w_pop_s = 1'b0;
        endcase
    end

    // Frame sequencer; serOut always presents the bit of the state being entered.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state_r  <= S_IDLE;
            r_hdr_r    <= 6'd0;
            r_len_r    <= 4'd0;
            r_phase_r  <= 2'd0;
            r_bits_r   <= 7'd0;
            r_shift_r  <= 8'd0;
            r_ser_r    <= 1'b1;
            r_busy_r   <= 1'b0;
            r_done_r   <= 1'b0;
            r_reject_r <= 1'b0;
        end else begin
            r_done_r   <= 1'b0;
            r_reject_r <= 1'b0;
            case (r_state_r)
                S_IDLE: begin
                    r_ser_r <= 1'b1;
                    if (start) begin
                        if (r_count_r >= CW'(byteNum)) begin
                            r_hdr_r   <= {portNum, byteNum};
                            r_len_r   <= byteNum;
                            r_ser_r   <= 1'b0;
                            r_busy_r  <= 1'b1;
                            r_state_r <= S_STRT;
                        end else begin
                            r_reject_r <= 1'b1;
                        end
                    end
                end
                S_STRT: begin
                    r_ser_r   <= r_hdr_r[5];
                    r_hdr_r   <= {r_hdr_r[4:0], 1'b0};
                    r_phase_r <= 2'd0;
                    r_state_r <= S_PORT;
                end
                S_PORT: begin
                    r_ser_r <= r_hdr_r[5];
                    r_hdr_r <= {r_hdr_r[4:0], 1'b0};
                    if (r_phase_r == 2'd1) begin
                        r_phase_r <= 2'd0;
                        r_state_r <= S_LEN;
                    end else begin
                        r_phase_r <= r_phase_r + 2'd1;
                    end
                end
                S_LEN: begin
                    if (r_phase_r == 2'd3) begin
                        if (r_len_r == 4'd0) begin
                            r_ser_r   <= 1'b1;
                            r_busy_r  <= 1'b0;
                            r_done_r  <= 1'b1;
                            r_state_r <= S_DONE;
                        end else begin
                            r_ser_r   <= w_rd_data_s[7];
                            r_shift_r <= {w_rd_data_s[6:0], 1'b0};
                            r_bits_r  <= {r_len_r, 3'b000};
                            r_state_r <= S_DATA;
                        end
                    end else begin
                        r_ser_r   <= r_hdr_r[5];
                        r_hdr_r   <= {r_hdr_r[4:0], 1'b0};
                        r_phase_r <= r_phase_r + 2'd1;
                    end
                end
                S_DATA: begin
                    r_bits_r <= r_bits_r - 7'd1;
                    if (r_bits_r == 7'd1) begin
                        r_ser_r   <= 1'b1;
                        r_busy_r  <= 1'b0;
                        r_done_r  <= 1'b1;
                        r_state_r <= S_DONE;
                    end else if (w_pop_s) begin
                        r_ser_r   <= w_rd_data_s[7];
                        r_shift_r <= {w_rd_data_s[6:0], 1'b0};
                    end else begin
                        r_ser_r   <= r_shift_r[7];
                        r_shift_r <= {r_shift_r[6:0], 1'b0};
                    end
                end
                S_DONE: begin
                    r_ser_r   <= 1'b1;
                    r_state_r <= S_IDLE;
                end
                default: begin
                    r_ser_r   <= 1'b1;
                    r_busy_r  <= 1'b0;
                    r_state_r <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and full flag.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr_r <= '0;
            r_rd_ptr_r <= '0;
            r_count_r  <= '0;
            r_full_r   <= 1'b0;
        end else begin
            if (w_push_s) begin
                r_wr_ptr_r <= r_wr_ptr_r + PW'(1);
            end
            if (w_pop_s) begin
                r_rd_ptr_r <= r_rd_ptr_r + PW'(1);
            end
            case ({w_push_s, w_pop_s})
                2'b10: begin
                    r_count_r <= r_count_r + CW'(1);
                    r_full_r  <= ((r_count_r + CW'(1)) == CW'(FIFO_DEPTH));
                end
                2'b01: begin
                    r_count_r <= r_count_r - CW'(1);
                    r_full_r  <= 1'b0;
                end
                default: begin
                    r_count_r <= r_count_r;
                    r_full_r  <= r_full_r;
                end
            endcase
        end
    end

    // Payload storage; contents need no reset because the pointers define validity.
    always_ff @(posedge Clk) begin
        if (w_push_s) begin
            r_mem_r[r_wr_ptr_r] <= dataIn;
        end
    end

    assign serOut    = r_ser_r;
    assign full      = r_full_r;
    assign fifoCount = r_count_r;
    assign busy      = r_busy_r;
    assign done      = r_done_r;
    assign reject    = r_reject_r;

endmodule

// File: tb/tb_mssd_frame_tx.sv
// Directed bench for mssd_frame_tx: table of single frames plus hand-written
// sequences for full-FIFO, push-on-pop, busy start and mid-frame reset.
module tb_mssd_frame_tx;

    logic       Clk;
    logic       reset;
    logic       wrEn;
    logic [7:0] dataIn;
    logic       start;
    logic [1:0] portNum;
    logic [3:0] byteNum;
    logic       serOut;
    logic       full;
    logic [4:0] fifoCount;
    logic       busy;
    logic       done;
    logic       reject;

    int n_cmp = 0;
    int n_err = 0;

    mssd_frame_tx #(.FIFO_DEPTH(16)) dut (
        .Clk(Clk), .reset(reset), .wrEn(wrEn), .dataIn(dataIn), .start(start),
        .portNum(portNum), .byteNum(byteNum), .serOut(serOut), .full(full),
        .fifoCount(fifoCount), .busy(busy), .done(done), .reject(reject)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [1:0]  port;
        logic [3:0]  len;
        int          npush;
        logic [15:0] bytes;
        int          nbits;
        logic [22:0] bits;
        logic        rej;
        int          cnt_after;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [126:0] hdr(input logic [1:0] p, input logic [3:0] n);
        return {120'd0, 1'b0, p, n};
    endfunction

    function automatic logic [126:0] add_byte(input logic [126:0] v, input logic [7:0] b);
        return (v << 8) | {119'd0, b};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        wrEn  = 1'b0;
        start = 1'b0;
        @(negedge Clk);
        chk("rst_serOut", serOut, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifoCount, 0);
        chk("rst_full", full, 0);
        chk("rst_done_reject", {done, reject}, 0);
        reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic push(input logic [7:0] b);
        wrEn   = 1'b1;
        dataIn = b;
        @(negedge Clk);
        wrEn   = 1'b0;
    endtask

    // mode 0: plain frame; mode 1: push-on-pop and start while busy; mode 2: reset at bit 20
    task automatic run_frame(input logic [1:0] p, input logic [3:0] n, input int nbits,
                             input logic [126:0] bits, input int mode);
        int busy_bad = 0;
        portNum = p;
        byteNum = n;
        start   = 1'b1;
        @(negedge Clk);
        start   = 1'b0;
        portNum = ~p;
        byteNum = ~n;
        for (int i = 0; i < nbits; i++) begin
            chk("frame_bit", serOut, bits[nbits-1-i]);
            if (busy !== 1'b1) busy_bad++;
            if (mode == 1 && i == 6) begin
                chk("cnt_before_pop", fifoCount, 16);
                wrEn   = 1'b1;
                dataIn = 8'hAA;
                start  = 1'b1;
            end
            if (mode == 1 && i == 7) begin
                wrEn  = 1'b0;
                start = 1'b0;
                chk("cnt_push_on_pop", fifoCount, 16);
                chk("full_push_on_pop", full, 1);
                chk("no_reject_busy", reject, 0);
            end
            if (mode == 2 && i == 19) begin
                #1 reset = 1'b0;
                #1;
                chk("async_rst_serOut", serOut, 1);
                chk("async_rst_count", fifoCount, 0);
                chk("async_rst_busy", busy, 0);
                return;
            end
            @(negedge Clk);
        end
        chk("busy_during_frame", busy_bad, 0);
        chk("done_pulse", done, 1);
        chk("done_serOut", serOut, 1);
        chk("done_busy", busy, 0);
        @(negedge Clk);
        chk("done_cleared", done, 0);
    endtask

    initial begin
        logic [126:0] v;
        reset   = 1'b0;
        wrEn    = 1'b0;
        dataIn  = 8'h00;
        start   = 1'b0;
        portNum = 2'b00;
        byteNum = 4'd0;

        vecs[0] = '{2'b10, 4'd1, 1, 16'hA500, 15, 23'(15'b010000110100101), 1'b0, 0};
        vecs[1] = '{2'b01, 4'd0, 0, 16'h0000, 7, 23'(7'b0010000), 1'b0, 0};
        vecs[2] = '{2'b11, 4'd2, 2, 16'h3C5A, 23, 23'b0110010_00111100_01011010, 1'b0, 0};
        vecs[3] = '{2'b00, 4'd3, 2, 16'h1122, 7, 23'd0, 1'b1, 2};
        vecs[4] = '{2'b00, 4'd1, 2, 16'hC3FF, 15, 23'(15'b0000001_11000011), 1'b0, 1};

        for (int r = 0; r < 5; r++) begin
            do_reset();
            if (vecs[r].npush > 0) push(vecs[r].bytes[15:8]);
            if (vecs[r].npush > 1) push(vecs[r].bytes[7:0]);
            chk("count_after_push", fifoCount, 32'(vecs[r].npush));
            if (vecs[r].rej) begin
                portNum = vecs[r].port;
                byteNum = vecs[r].len;
                start   = 1'b1;
                @(negedge Clk);
                start   = 1'b0;
                chk("reject_pulse", reject, 1);
                chk("reject_serOut", serOut, 1);
                chk("reject_busy", busy, 0);
                @(negedge Clk);
                chk("reject_cleared", reject, 0);
                chk("reject_serOut_idle", serOut, 1);
            end else begin
                run_frame(vecs[r].port, vecs[r].len, vecs[r].nbits, 127'(vecs[r].bits), 0);
            end
            chk("count_after_frame", fifoCount, 32'(vecs[r].cnt_after));
        end

        // Fill past capacity, then a 15-byte frame with a push on the first pop edge.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            push(8'(k));
            if (k == 14) chk("full_at_15", full, 0);
            if (k == 15) chk("full_at_16", {27'd0, full, fifoCount}, 32'h30);
        end
        chk("count_drop_17th", fifoCount, 16);
        chk("full_drop_17th", full, 1);
        v = hdr(2'b00, 4'd15);
        for (int k = 0; k < 15; k++) v = add_byte(v, 8'(k));
        run_frame(2'b00, 4'd15, 127, v, 1);
        chk("count_after_long", fifoCount, 2);
        v = add_byte(add_byte(hdr(2'b10, 4'd2), 8'h0F), 8'hAA);
        run_frame(2'b10, 4'd2, 23, v, 0);
        chk("count_after_tail", fifoCount, 0);

        // Reset during the 20th bit of a 3-byte frame, then a clean frame.
        do_reset();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        v = add_byte(add_byte(add_byte(hdr(2'b01, 4'd3), 8'h11), 8'h22), 8'h33);
        run_frame(2'b01, 4'd3, 31, v, 2);
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        chk("post_rst_count", fifoCount, 0);
        chk("post_rst_serOut", serOut, 1);
        push(8'h3C);
        v = add_byte(hdr(2'b00, 4'd1), 8'h3C);
        run_frame(2'b00, 4'd1, 15, v, 0);
        chk("post_rst_final_count", fifoCount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
